// File: rtl/axis_i2s_arb_pkg.sv
// Shared definitions for the I2S TX source arbiter.
// Holds the mode encoding, the arbiter FSM state encoding and the default frame width.
// No logic lives here; the arbiter and its output register slice import it.
package axis_i2s_arb_pkg;

  // Default stereo frame width: [8'd0, r_data(24), 8'd0, l_data(24)]
  localparam int DEFAULT_DATA_WIDTH = 64;

  // Arbitration mode, sampled only between packets
  localparam logic [1:0] MODE_SRC0 = 2'd0;
  localparam logic [1:0] MODE_SRC1 = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;
  localparam logic [1:0] MODE_MUTE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_MUTE   = 2'd3
  } arb_state_t;

  // One-hot owner indication for a given state (00 when idle or muted)
  function automatic logic [1:0] state_grant(input arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == ST_GRANT0) g = 2'b01;
    if (st == ST_GRANT1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXIS register carrying data and tlast.
// Latency: one cycle from src handshake to dst valid.
// Backpressure: src_rdy = !dst_vld || dst_rdy; dst data/last held while stalled.
//
// Ports:
//   aclk, resetn          clock, asynchronous active-low reset
//   src_dat/last/vld/rdy  upstream side of the stage
//   dst_dat/last/vld/rdy  downstream (registered) side of the stage
module axis_reg_slice
  import axis_i2s_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] src_dat,
  input  logic                  src_last,
  input  logic                  src_vld,
  output logic                  src_rdy,
  output logic [DATA_WIDTH-1:0] dst_dat,
  output logic                  dst_last,
  output logic                  dst_vld,
  input  logic                  dst_rdy
);

  // The stage can take a new beat when empty or when its beat leaves this cycle
  assign src_rdy = !dst_vld || dst_rdy;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      dst_vld  <= 1'b0;
      dst_dat  <= '0;
      dst_last <= 1'b0;
    end else if (src_rdy) begin
      dst_vld <= src_vld;
      if (src_vld) begin
        dst_dat  <= src_dat;
        dst_last <= src_last;
      end
    end
  end

endmodule

// File: rtl/axis_i2s_src_arbiter.sv
// Packet-level arbiter sharing the I2S TX AXIS frame input between two sources.
// Latency: one cycle from source acceptance to m_axis; IDLE->GRANT costs one idle cycle.
// Backpressure: sources see tready only when granted and the output stage can load.
//
// Ports:
//   aclk, resetn       clock, asynchronous active-low reset
//   mode               0 fixed src0, 1 fixed src1, 2 round-robin, 3 mute
//   s0_axis_*          source 0 stereo frames (tdata/tvalid/tlast/tready)
//   s1_axis_*          source 1 stereo frames (tdata/tvalid/tlast/tready)
//   m_axis_*           registered frames towards the I2S TX slave
//   grant              one-hot current owner, 00 when idle or muted
//   underrun_count     saturating underrun counter, only with AXIS_I2S_ARB_UNDERRUN_EN
module axis_i2s_src_arbiter
  import axis_i2s_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [1:0]            grant
`ifdef AXIS_I2S_ARB_UNDERRUN_EN
  ,
  output logic [CNT_WIDTH-1:0]  underrun_count
`endif
);

  // Beat counter holds 0..MAX_BEATS, so it never wraps
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BEATS);

  // A zero beat budget or zero-width counter is not a meaningful build
  if (MAX_BEATS < 1 || CNT_WIDTH < 1) begin : g_bad_params
  end

  arb_state_t            state;
  logic                  last_grant;  // 0 = src0 served last, 1 = src1
  logic [BW-1:0]         beat_cnt;
  logic [BW-1:0]         beat_cnt_nxt;
  logic                  load;
  logic                  acc0;
  logic                  acc1;
  logic [DATA_WIDTH-1:0] fwd_dat;
  logic                  fwd_last;
  logic                  fwd_vld;

  assign s0_axis_tready = load && (state == ST_GRANT0);
  assign s1_axis_tready = load && (state == ST_GRANT1);
  assign acc0           = s0_axis_tvalid && s0_axis_tready;
  assign acc1           = s1_axis_tvalid && s1_axis_tready;
  assign beat_cnt_nxt   = beat_cnt + 1'b1;

  // Feed for the output stage: granted source, or a zero end-of-packet frame when muted
  always_comb begin
    fwd_vld  = 1'b0;
    fwd_dat  = '0;
    fwd_last = 1'b0;
    case (state)
      ST_GRANT0: begin
        fwd_vld  = s0_axis_tvalid;
        fwd_dat  = s0_axis_tdata;
        fwd_last = s0_axis_tlast;
      end
      ST_GRANT1: begin
        fwd_vld  = s1_axis_tvalid;
        fwd_dat  = s1_axis_tdata;
        fwd_last = s1_axis_tlast;
      end
      ST_MUTE: begin
        fwd_vld  = 1'b1;
        fwd_last = 1'b1;
      end
      default: ;
    endcase
  end

  axis_reg_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .aclk     (aclk),
    .resetn   (resetn),
    .src_dat  (fwd_dat),
    .src_last (fwd_last),
    .src_vld  (fwd_vld),
    .src_rdy  (load),
    .dst_dat  (m_axis_tdata),
    .dst_last (m_axis_tlast),
    .dst_vld  (m_axis_tvalid),
    .dst_rdy  (m_axis_tready)
  );

  // Arbiter FSM; grant is registered alongside the state it mirrors
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          case (mode)
            MODE_SRC0: begin
              if (s0_axis_tvalid) begin
                state      <= ST_GRANT0;
                grant      <= state_grant(ST_GRANT0);
                last_grant <= 1'b0;
              end
            end
            MODE_SRC1: begin
              if (s1_axis_tvalid) begin
                state      <= ST_GRANT1;
                grant      <= state_grant(ST_GRANT1);
                last_grant <= 1'b1;
              end
            end
            MODE_RR: begin
              // src0 wins when alone, or on a tie after src1 was served last
              if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant)) begin
                state      <= ST_GRANT0;
                grant      <= state_grant(ST_GRANT0);
                last_grant <= 1'b0;
              end else if (s1_axis_tvalid) begin
                state      <= ST_GRANT1;
                grant      <= state_grant(ST_GRANT1);
                last_grant <= 1'b1;
              end
            end
            MODE_MUTE: begin
              state <= ST_MUTE;
              grant <= state_grant(ST_MUTE);
            end
            default: ;
          endcase
        end
        ST_GRANT0, ST_GRANT1: begin
          // A source that stops mid-packet keeps its grant (output underrun)
          if (acc0 || acc1) begin
            if ((acc0 && s0_axis_tlast) || (acc1 && s1_axis_tlast) ||
                (beat_cnt_nxt == MAX_CNT)) begin
              state    <= ST_IDLE;
              grant    <= state_grant(ST_IDLE);
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt_nxt;
            end
          end
        end
        ST_MUTE: begin
          // One zero frame per visit; mode is re-sampled in IDLE afterwards
          if (load) begin
            state <= ST_IDLE;
            grant <= state_grant(ST_IDLE);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

`ifdef AXIS_I2S_ARB_UNDERRUN_EN
  // Counts cycles where the TX wants a frame but none is offered outside IDLE
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      underrun_count <= '0;
    end else if ((state != ST_IDLE) && m_axis_tready && !m_axis_tvalid &&
                 (underrun_count != {CNT_WIDTH{1'b1}})) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_i2s_src_arbiter.sv
// Directed self-checking bench for axis_i2s_src_arbiter (MAX_BEATS = 8).
// Latency: n/a (testbench).
// Backpressure: bench sources hold tvalid while their queue is non-empty.
module tb_axis_i2s_src_arbiter;

  typedef logic [64:0] beat_t;  // {tlast, tdata}

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [63:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic        s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic        s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [1:0]  grant;
`ifdef AXIS_I2S_ARB_UNDERRUN_EN
  logic [15:0] underrun_count;
`endif

  int n_checks = 0;
  int n_pass = 0;

  beat_t      s0_q[$];
  beat_t      s1_q[$];
  beat_t      out_q[$];
  logic [1:0] gtrace[$];
  logic       s0_fire = 1'b0;
  logic       s1_fire = 1'b0;
  int         s0_rdy_cnt = 0;
  int         s1_rdy_cnt = 0;
  int         g01_cnt = 0;
  int         g10_cnt = 0;

  axis_i2s_src_arbiter #(
    .DATA_WIDTH (64),
    .MAX_BEATS  (8),
    .CNT_WIDTH  (16)
  ) dut (
    .aclk           (aclk),
    .resetn         (resetn),
    .mode           (mode),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .grant          (grant)
`ifdef AXIS_I2S_ARB_UNDERRUN_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial forever #5 aclk = ~aclk;

  // Source drivers: present queue head, pop after a handshake seen at the negedge
  initial begin
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (s0_fire && s0_q.size() > 0) void'(s0_q.pop_front());
      if (s1_fire && s1_q.size() > 0) void'(s1_q.pop_front());
      if (s0_q.size() > 0) begin
        s0_axis_tvalid = 1'b1;
        {s0_axis_tlast, s0_axis_tdata} = s0_q[0];
      end else begin
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
      end
      if (s1_q.size() > 0) begin
        s1_axis_tvalid = 1'b1;
        {s1_axis_tlast, s1_axis_tdata} = s1_q[0];
      end else begin
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
      end
    end
  end

  // Monitor: handshakes resolve at the next posedge; inputs are stable at the negedge
  initial forever begin
    @(negedge aclk);
    s0_fire = s0_axis_tvalid && s0_axis_tready;
    s1_fire = s1_axis_tvalid && s1_axis_tready;
    if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
    if (s0_axis_tready) s0_rdy_cnt++;
    if (s1_axis_tready) s1_rdy_cnt++;
    if (grant == 2'b01) g01_cnt++;
    if (grant == 2'b10) g10_cnt++;
    gtrace.push_back(grant);
  end

  function automatic logic [63:0] frame(input logic [23:0] r, input logic [23:0] l);
    return {8'h00, r, 8'h00, l};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic clear_all();
    s0_q.delete(); s1_q.delete(); out_q.delete(); gtrace.delete();
    s0_rdy_cnt = 0; s1_rdy_cnt = 0; g01_cnt = 0; g10_cnt = 0;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (out_q.size() < n)
      $display("FAIL %s_timeout: got %0d beats, required %0d", name, out_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    mode = 2'd0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); else n_pass++;
    n_checks++; if (m_axis_tdata !== 64'd0) $display("FAIL rst_tdata: got %h required 0", m_axis_tdata); else n_pass++;
    n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %b required 0", m_axis_tlast); else n_pass++;
    n_checks++; if (s0_axis_tready !== 1'b0) $display("FAIL rst_s0_tready: got %b required 0", s0_axis_tready); else n_pass++;
    n_checks++; if (s1_axis_tready !== 1'b0) $display("FAIL rst_s1_tready: got %b required 0", s1_axis_tready); else n_pass++;
    n_checks++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b required 00", grant); else n_pass++;
`ifdef AXIS_I2S_ARB_UNDERRUN_EN
    n_checks++; if (underrun_count !== 16'd0) $display("FAIL rst_underrun: got %0d required 0", underrun_count); else n_pass++;
`endif
    @(posedge aclk);
    #2;
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_d [8];
    logic [1:0]  exp_g [12];
    int st;
    exp_d = '{64'h000A0001_00000001, 64'h000A0001_00000002, 64'h000B0001_00000001, 64'h000B0001_00000002,
              64'h000A0002_00000001, 64'h000A0002_00000002, 64'h000B0002_00000001, 64'h000B0002_00000002};
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    clear_all();
    mode = 2'd2;
    s0_q.push_back({1'b0, 64'h000A0001_00000001}); s0_q.push_back({1'b1, 64'h000A0001_00000002});
    s0_q.push_back({1'b0, 64'h000A0002_00000001}); s0_q.push_back({1'b1, 64'h000A0002_00000002});
    s1_q.push_back({1'b0, 64'h000B0001_00000001}); s1_q.push_back({1'b1, 64'h000B0001_00000002});
    s1_q.push_back({1'b0, 64'h000B0002_00000001}); s1_q.push_back({1'b1, 64'h000B0002_00000002});
    wait_out(8, 60, "rr");
    tick(3);
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== {i[0], exp_d[i]})
        $display("FAIL rr_beat%0d: got %h required %h", i, out_q[i], {i[0], exp_d[i]});
      else n_pass++;
    end
    st = -1;
    foreach (gtrace[i]) if (st < 0 && gtrace[i] == 2'b01) st = i;
    n_checks++;
    if (st < 0 || st + 12 > gtrace.size()) begin
      $display("FAIL rr_grant_trace: got start %0d of %0d entries, required a full 12-cycle window", st, gtrace.size());
    end else begin
      n_pass++;
      for (int j = 0; j < 12; j++) begin
        n_checks++;
        if (gtrace[st + j] !== exp_g[j])
          $display("FAIL rr_grant_cyc%0d: got %b required %b", j, gtrace[st + j], exp_g[j]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_fixed_src0();
    clear_all();
    mode = 2'd0;
    for (int i = 0; i < 4; i++) s0_q.push_back({(i == 3), 64'h00AAAAAA_00555555});
    for (int i = 0; i < 6; i++) s1_q.push_back({1'b0, frame(24'h0B0000, 24'(i))});
    wait_out(4, 40, "fixed");
    tick(5);
    n_checks++; if (out_q.size() !== 4) $display("FAIL fixed_count: got %0d required 4", out_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== {(i == 3), 64'h00AAAAAA_00555555})
        $display("FAIL fixed_beat%0d: got %h required %h", i, out_q[i], {(i == 3), 64'h00AAAAAA_00555555});
      else n_pass++;
    end
    n_checks++; if (s1_rdy_cnt !== 0) $display("FAIL fixed_s1_tready: got %0d ready cycles required 0", s1_rdy_cnt); else n_pass++;
    n_checks++; if (g01_cnt !== 4) $display("FAIL fixed_grant01: got %0d cycles required 4", g01_cnt); else n_pass++;
    n_checks++; if (g10_cnt !== 0) $display("FAIL fixed_grant10: got %0d cycles required 0", g10_cnt); else n_pass++;
    s1_q.delete();
    tick(3);
  endtask

  task automatic test_stall();
    logic [63:0] held;
    clear_all();
    mode = 2'd2;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) s0_q.push_back({(i == 3), frame(24'h0C0000, 24'(i))});
    wait_out(1, 20, "stall_first");
    m_axis_tready = 1'b0;
    @(negedge aclk);
    held = m_axis_tdata;
    n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL stall_tvalid: got %b required 1", m_axis_tvalid); else n_pass++;
    n_checks++; if (held !== 64'h000C0000_00000001) $display("FAIL stall_tdata: got %h required %h", held, 64'h000C0000_00000001); else n_pass++;
    n_checks++; if (s0_axis_tready !== 1'b0) $display("FAIL stall_s0_tready: got %b required 0", s0_axis_tready); else n_pass++;
    tick();
    @(negedge aclk);
    n_checks++; if (m_axis_tdata !== 64'h000C0000_00000001) $display("FAIL stall_hold_tdata: got %h required %h", m_axis_tdata, 64'h000C0000_00000001); else n_pass++;
    n_checks++; if (m_axis_tlast !== 1'b0 || m_axis_tvalid !== 1'b1) $display("FAIL stall_hold_ctl: got last %b valid %b required 0 1", m_axis_tlast, m_axis_tvalid); else n_pass++;
    tick();
    m_axis_tready = 1'b1;
    wait_out(4, 30, "stall");
    tick(3);
    n_checks++; if (out_q.size() !== 4) $display("FAIL stall_count: got %0d required 4", out_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== {(i == 3), frame(24'h0C0000, 24'(i))})
        $display("FAIL stall_beat%0d: got %h required %h", i, out_q[i], {(i == 3), frame(24'h0C0000, 24'(i))});
      else n_pass++;
    end
  endtask

  task automatic test_max_beats();
    beat_t exp_q[$];
    clear_all();
    mode = 2'd2;
    for (int i = 0; i < 21; i++) s0_q.push_back({(i == 20), frame(24'h0D0000, 24'(i))});
    tick(3);
    s1_q.push_back({1'b0, frame(24'h0E0000, 24'd0)});
    s1_q.push_back({1'b1, frame(24'h0E0000, 24'd1)});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, frame(24'h0D0000, 24'(i))});
    exp_q.push_back({1'b0, frame(24'h0E0000, 24'd0)});
    exp_q.push_back({1'b1, frame(24'h0E0000, 24'd1)});
    for (int i = 8; i < 21; i++) exp_q.push_back({(i == 20), frame(24'h0D0000, 24'(i))});
    wait_out(23, 80, "maxb");
    tick(3);
    n_checks++; if (out_q.size() !== 23) $display("FAIL maxb_count: got %0d required 23", out_q.size()); else n_pass++;
    for (int i = 0; i < 23 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) $display("FAIL maxb_beat%0d: got %h required %h", i, out_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (g10_cnt !== 2) $display("FAIL maxb_grant10: got %0d cycles required 2", g10_cnt); else n_pass++;
    n_checks++; if (g01_cnt !== 21) $display("FAIL maxb_grant01: got %0d cycles required 21", g01_cnt); else n_pass++;
  endtask

  task automatic test_mute();
    clear_all();
    mode = 2'd0;
    for (int i = 0; i < 4; i++) s0_q.push_back({(i == 3), frame(24'h0F0000, 24'(i))});
    s0_q.push_back({1'b0, frame(24'h0F0001, 24'd0)});
    s0_q.push_back({1'b1, frame(24'h0F0001, 24'd1)});
    s1_q.push_back({1'b1, frame(24'h0F0002, 24'd0)});
    wait_out(1, 20, "mute_first");
    mode = 2'd3;
    wait_out(8, 60, "mute");
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      beat_t exp_b;
      exp_b = (i < 4) ? {(i == 3), frame(24'h0F0000, 24'(i))} : {1'b1, 64'd0};
      n_checks++;
      if (out_q[i] !== exp_b) $display("FAIL mute_beat%0d: got %h required %h", i, out_q[i], exp_b);
      else n_pass++;
    end
    n_checks++; if (s1_rdy_cnt !== 0) $display("FAIL mute_s1_ever_ready: got %0d cycles required 0", s1_rdy_cnt); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      n_checks++;
      if (s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0)
        $display("FAIL mute_tready%0d: got %b%b required 00", i, s1_axis_tready, s0_axis_tready);
      else n_pass++;
    end
    tick();
    s0_q.delete(); s1_q.delete();
    mode = 2'd2;
    tick(4);
  endtask

  task automatic test_reset_mid_packet();
    clear_all();
    mode = 2'd2;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) s0_q.push_back({(i == 5), frame(24'h010000, 24'(i))});
    wait_out(2, 20, "rstmid_pre");
    @(posedge aclk);
    #3;
    resetn = 1'b0;
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rstmid_tvalid: got %b required 0", m_axis_tvalid); else n_pass++;
    n_checks++; if (grant !== 2'b00) $display("FAIL rstmid_grant: got %b required 00", grant); else n_pass++;
    n_checks++; if (s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0)
      $display("FAIL rstmid_tready: got %b%b required 00", s1_axis_tready, s0_axis_tready); else n_pass++;
    tick(2);
    clear_all();
    @(posedge aclk);
    #3;
    resetn = 1'b1;
    tick();
    s0_q.push_back({1'b0, frame(24'h020000, 24'd0)});
    s0_q.push_back({1'b1, frame(24'h020000, 24'd1)});
    s1_q.push_back({1'b0, frame(24'h030000, 24'd0)});
    s1_q.push_back({1'b1, frame(24'h030000, 24'd1)});
    wait_out(4, 30, "rstmid_post");
    tick(2);
    if (out_q.size() >= 4) begin
      n_checks++; if (out_q[0] !== {1'b0, 64'h00020000_00000000}) $display("FAIL rstmid_first: got %h required %h", out_q[0], {1'b0, 64'h00020000_00000000}); else n_pass++;
      n_checks++; if (out_q[2] !== {1'b0, 64'h00030000_00000000}) $display("FAIL rstmid_third: got %h required %h", out_q[2], {1'b0, 64'h00030000_00000000}); else n_pass++;
    end
  endtask

`ifdef AXIS_I2S_ARB_UNDERRUN_EN
  task automatic test_underrun();
    int k;
    clear_all();
    mode = 2'd2;
    m_axis_tready = 1'b0;
    s0_q.push_back({1'b0, frame(24'h040000, 24'd0)});
    k = 0;
    while (m_axis_tvalid !== 1'b1 && k < 20) begin
      @(negedge aclk);
      k++;
    end
    n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL udr_wait_valid: got %b required 1", m_axis_tvalid); else n_pass++;
    @(posedge aclk);
    #2;
    m_axis_tready = 1'b1;
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    n_checks++; if (underrun_count !== 16'd5) $display("FAIL udr_count: got %0d required 5", underrun_count); else n_pass++;
    tick();
    s0_q.push_back({1'b1, frame(24'h040000, 24'd1)});
    wait_out(2, 20, "udr_close");
    tick(3);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_src0();
    test_stall();
    test_max_beats();
    test_mute();
    test_reset_mid_packet();
`ifdef AXIS_I2S_ARB_UNDERRUN_EN
    test_underrun();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
